// File: rtl/spi_cmd_decoder.sv
// SPI mode-0 slave that deserialises two-byte command frames into the clk domain.
// Reports roll frames, unknown commands and malformed or stalled frames as one-cycle strobes.
module spi_cmd_decoder #(
    parameter logic [7:0]  CMD_ROLL       = 8'h41,
    parameter int unsigned SYNC_STAGES    = 2,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sclk,
    input  logic       mosi,
    input  logic       cs_n,
    output logic       roll_valid,
    output logic [7:0] roll_data,
    output logic       unk_cmd,
    output logic [7:0] cmd_code,
    output logic       frame_err,
    output logic       busy
);

    localparam int unsigned     TO_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        RX_CMD,
        RX_DATA,
        WAIT_END
    } state_t;

    logic [SYNC_STAGES-1:0] r_sclk_sync;
    logic [SYNC_STAGES-1:0] r_mosi_sync;
    logic [SYNC_STAGES-1:0] r_cs_sync;
    logic                   r_sclk_prev;
    logic                   r_cs_prev;
    logic [SYNC_STAGES:0]   r_boot;

    logic w_sclk_s;
    logic w_mosi_s;
    logic w_cs_s;
    logic w_sclk_rise;
    logic w_cs_rise;
    logic w_cs_fall;
    logic w_boot;

    state_t          r_state;
    logic [15:0]     r_shift;
    logic [4:0]      r_bit_cnt;
    logic [TO_W-1:0] r_to_cnt;

    assign w_sclk_s    = r_sclk_sync[SYNC_STAGES-1];
    assign w_mosi_s    = r_mosi_sync[SYNC_STAGES-1];
    assign w_cs_s      = r_cs_sync[SYNC_STAGES-1];
    assign w_sclk_rise = w_sclk_s & ~r_sclk_prev;
    assign w_cs_rise   = w_cs_s & ~r_cs_prev;
    assign w_cs_fall   = ~w_cs_s & r_cs_prev;
    // Stays high until the first post-reset sample of cs_n has crossed the
    // synchroniser, so a frame already in progress at reset lands in WAIT_END.
    assign w_boot      = r_boot[SYNC_STAGES];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sclk_sync <= '0;
            r_mosi_sync <= '0;
            r_cs_sync   <= '1;
            r_sclk_prev <= 1'b0;
            r_cs_prev   <= 1'b1;
            r_boot      <= '1;
        end else begin
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], sclk};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], mosi};
            r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], cs_n};
            r_sclk_prev <= w_sclk_s;
            r_cs_prev   <= w_cs_s;
            r_boot      <= {r_boot[SYNC_STAGES-1:0], 1'b0};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_shift    <= '0;
            r_bit_cnt  <= '0;
            r_to_cnt   <= '0;
            roll_valid <= 1'b0;
            roll_data  <= '0;
            unk_cmd    <= 1'b0;
            cmd_code   <= '0;
            frame_err  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            roll_valid <= 1'b0;
            unk_cmd    <= 1'b0;
            frame_err  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_cs_fall) begin
                        r_bit_cnt <= '0;
                        r_to_cnt  <= '0;
                        r_state   <= w_boot ? WAIT_END : RX_CMD;
                        busy      <= 1'b1;
                    end
                end
                RX_CMD, RX_DATA: begin
                    // cs_n rise has priority: a coincident sclk rise is dropped.
                    if (w_cs_rise) begin
                        r_state <= IDLE;
                        busy    <= 1'b0;
                        if (r_bit_cnt == 5'd16) begin
                            cmd_code <= r_shift[15:8];
                            if (r_shift[15:8] == CMD_ROLL) begin
                                roll_valid <= 1'b1;
                                roll_data  <= r_shift[7:0];
                            end else begin
                                unk_cmd <= 1'b1;
                            end
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end else if (w_sclk_rise) begin
                        r_shift  <= {r_shift[14:0], w_mosi_s};
                        r_to_cnt <= '0;
                        if (r_bit_cnt != 5'd17) begin
                            r_bit_cnt <= r_bit_cnt + 5'd1;
                        end
                        if (r_state == RX_CMD && r_bit_cnt == 5'd7) begin
                            r_state <= RX_DATA;
                        end
                    end else if (r_to_cnt == TO_LAST) begin
                        r_state   <= WAIT_END;
                        frame_err <= 1'b1;
                    end else begin
                        r_to_cnt <= r_to_cnt + TO_W'(1);
                    end
                end
                WAIT_END: begin
                    if (w_cs_rise) begin
                        r_state <= IDLE;
                        busy    <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_cmd_decoder.sv
// Self-checking bench for spi_cmd_decoder: directed scenarios plus randomized frames
// compared against a frame-level reference model.
module tb_spi_cmd_decoder;

    localparam logic [7:0] CMD_ROLL = 8'h41;
    localparam int         SYNC     = 2;
    localparam int         TIMEOUT  = 1024;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       sclk;
    logic       mosi;
    logic       cs_n;
    logic       roll_valid;
    logic [7:0] roll_data;
    logic       unk_cmd;
    logic [7:0] cmd_code;
    logic       frame_err;
    logic       busy;

    always #5 clk = ~clk;

    spi_cmd_decoder #(
        .CMD_ROLL      (CMD_ROLL),
        .SYNC_STAGES   (SYNC),
        .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sclk      (sclk),
        .mosi      (mosi),
        .cs_n      (cs_n),
        .roll_valid(roll_valid),
        .roll_data (roll_data),
        .unk_cmd   (unk_cmd),
        .cmd_code  (cmd_code),
        .frame_err (frame_err),
        .busy      (busy)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Observations gathered on the falling edge.
    int         obs_roll = 0, obs_unk = 0, obs_err = 0, obs_multi = 0, obs_busy_rise = 0;
    logic       prev_busy = 1'b0;
    logic [7:0] obs_roll_q[$];

    always @(negedge clk) begin
        if (roll_valid) begin
            obs_roll++;
            obs_roll_q.push_back(roll_data);
        end
        if (unk_cmd) obs_unk++;
        if (frame_err) obs_err++;
        if (int'(roll_valid) + int'(unk_cmd) + int'(frame_err) > 1) obs_multi++;
        if (busy === 1'b1 && prev_busy === 1'b0) obs_busy_rise++;
        prev_busy = busy;
    end

    // Frame-level reference model.
    int         exp_roll = 0, exp_unk = 0, exp_err = 0;
    logic [7:0] exp_roll_data = 8'h00;
    logic [7:0] exp_cmd = 8'h00;
    int         half = 4;

    task automatic model_frame(input logic [31:0] vec, input int n);
        logic [7:0] c;
        if (n == 16) begin
            c = vec[15:8];
            exp_cmd = c;
            if (c == CMD_ROLL) begin
                exp_roll++;
                exp_roll_data = vec[7:0];
            end else begin
                exp_unk++;
            end
        end else begin
            exp_err++;
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic cs_low();
        cs_n = 1'b0;
        tick(4);
    endtask

    task automatic send_bits(input logic [31:0] vec, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            mosi = vec[i];
            tick(half);
            sclk = 1'b1;
            tick(half);
            sclk = 1'b0;
        end
        tick(half);
    endtask

    task automatic cs_high(input int gap);
        cs_n = 1'b1;
        tick(gap);
    endtask

    task automatic send_frame(input logic [31:0] vec, input int n, input int gap);
        cs_low();
        send_bits(vec, n);
        cs_high(gap);
        model_frame(vec, n);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; cs_n = 1'b1; sclk = 1'b0; mosi = 1'b0;
        tick(4);
        n_tests++; if (roll_valid !== 1'b0) begin n_fail++; $display("FAIL reset_roll_valid: got %b expected 0", roll_valid); end
        n_tests++; if (unk_cmd !== 1'b0) begin n_fail++; $display("FAIL reset_unk_cmd: got %b expected 0", unk_cmd); end
        n_tests++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_frame_err: got %b expected 0", frame_err); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_tests++; if (roll_data !== 8'h00) begin n_fail++; $display("FAIL reset_roll_data: got %h expected 00", roll_data); end
        n_tests++; if (cmd_code !== 8'h00) begin n_fail++; $display("FAIL reset_cmd_code: got %h expected 00", cmd_code); end
        rst_n = 1'b1;
        tick(8);
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL post_reset_busy: got %b expected 0", busy); end
    endtask

    task automatic test_roll();
        send_frame(32'h0000_415A, 16, 8);
        n_tests++; if (obs_roll !== exp_roll) begin n_fail++; $display("FAIL roll_count: got %0d expected %0d", obs_roll, exp_roll); end
        n_tests++; if (obs_unk !== exp_unk) begin n_fail++; $display("FAIL roll_unk_count: got %0d expected %0d", obs_unk, exp_unk); end
        n_tests++; if (obs_err !== exp_err) begin n_fail++; $display("FAIL roll_err_count: got %0d expected %0d", obs_err, exp_err); end
        n_tests++; if (roll_data !== exp_roll_data) begin n_fail++; $display("FAIL roll_data: got %h expected %h", roll_data, exp_roll_data); end
        n_tests++; if (cmd_code !== exp_cmd) begin n_fail++; $display("FAIL roll_cmd_code: got %h expected %h", cmd_code, exp_cmd); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL roll_busy: got %b expected 0", busy); end
    endtask

    task automatic test_unknown();
        send_frame(32'h0000_22FF, 16, 8);
        n_tests++; if (obs_unk !== exp_unk) begin n_fail++; $display("FAIL unk_count: got %0d expected %0d", obs_unk, exp_unk); end
        n_tests++; if (obs_roll !== exp_roll) begin n_fail++; $display("FAIL unk_roll_count: got %0d expected %0d", obs_roll, exp_roll); end
        n_tests++; if (cmd_code !== exp_cmd) begin n_fail++; $display("FAIL unk_cmd_code: got %h expected %h", cmd_code, exp_cmd); end
        n_tests++; if (roll_data !== exp_roll_data) begin n_fail++; $display("FAIL unk_roll_data_hold: got %h expected %h", roll_data, exp_roll_data); end
    endtask

    task automatic test_bad_length();
        send_frame(32'h0000_0A5C, 12, 8);
        send_frame(32'h0001_4142, 17, 8);
        n_tests++; if (obs_err !== exp_err) begin n_fail++; $display("FAIL badlen_err_count: got %0d expected %0d", obs_err, exp_err); end
        n_tests++; if (obs_roll !== exp_roll) begin n_fail++; $display("FAIL badlen_roll_count: got %0d expected %0d", obs_roll, exp_roll); end
        n_tests++; if (obs_unk !== exp_unk) begin n_fail++; $display("FAIL badlen_unk_count: got %0d expected %0d", obs_unk, exp_unk); end
        n_tests++; if (roll_data !== exp_roll_data) begin n_fail++; $display("FAIL badlen_roll_data: got %h expected %h", roll_data, exp_roll_data); end
        n_tests++; if (cmd_code !== exp_cmd) begin n_fail++; $display("FAIL badlen_cmd_code: got %h expected %h", cmd_code, exp_cmd); end
    endtask

    task automatic test_timeout();
        cs_low();
        send_bits(32'h0000_0016, 5);
        tick(TIMEOUT + 80);
        exp_err++;
        n_tests++; if (obs_err !== exp_err) begin n_fail++; $display("FAIL timeout_err: got %0d expected %0d", obs_err, exp_err); end
        n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL timeout_busy_wait_end: got %b expected 1", busy); end
        send_bits(32'h0000_0005, 3);
        cs_high(8);
        n_tests++; if (obs_err !== exp_err) begin n_fail++; $display("FAIL timeout_no_second_err: got %0d expected %0d", obs_err, exp_err); end
        n_tests++; if (obs_roll + obs_unk !== exp_roll + exp_unk) begin n_fail++; $display("FAIL timeout_no_strobe: got %0d expected %0d", obs_roll + obs_unk, exp_roll + exp_unk); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL timeout_busy_idle: got %b expected 0", busy); end
        send_frame(32'h0000_4133, 16, 8);
        n_tests++; if (roll_data !== exp_roll_data) begin n_fail++; $display("FAIL timeout_next_roll_data: got %h expected %h", roll_data, exp_roll_data); end
        n_tests++; if (obs_roll !== exp_roll) begin n_fail++; $display("FAIL timeout_next_roll_count: got %0d expected %0d", obs_roll, exp_roll); end
    endtask

    task automatic test_reset_midframe();
        logic [31:0] v;
        v = 32'h0000_417E;
        cs_low();
        send_bits(v >> 6, 10);
        rst_n = 1'b0;
        exp_roll_data = 8'h00;
        exp_cmd = 8'h00;
        tick(3);
        n_tests++; if (roll_data !== exp_roll_data) begin n_fail++; $display("FAIL rstmid_roll_data: got %h expected %h", roll_data, exp_roll_data); end
        rst_n = 1'b1;
        tick(8);
        n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rstmid_busy_wait_end: got %b expected 1", busy); end
        send_bits(v, 6);
        cs_high(8);
        n_tests++; if (obs_roll + obs_unk + obs_err !== exp_roll + exp_unk + exp_err) begin n_fail++; $display("FAIL rstmid_no_strobe: got %0d expected %0d", obs_roll + obs_unk + obs_err, exp_roll + exp_unk + exp_err); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy_idle: got %b expected 0", busy); end
        send_frame(32'h0000_4101, 16, 8);
        n_tests++; if (roll_data !== exp_roll_data) begin n_fail++; $display("FAIL rstmid_next_roll_data: got %h expected %h", roll_data, exp_roll_data); end
        n_tests++; if (cmd_code !== exp_cmd) begin n_fail++; $display("FAIL rstmid_next_cmd_code: got %h expected %h", cmd_code, exp_cmd); end
    endtask

    task automatic test_back_to_back();
        int base_q;
        int base_rise;
        logic [7:0] want;
        half = 4;
        base_q = obs_roll_q.size();
        base_rise = obs_busy_rise;
        for (int d = 1; d <= 3; d++) begin
            send_frame({16'h0, CMD_ROLL, 8'(d)}, 16, SYNC + 2);
        end
        tick(8);
        n_tests++; if (obs_roll_q.size() - base_q !== 3) begin n_fail++; $display("FAIL b2b_count: got %0d expected 3", obs_roll_q.size() - base_q); end
        for (int k = 0; k < 3; k++) begin
            want = 8'(k + 1);
            n_tests++;
            if (base_q + k >= obs_roll_q.size()) begin
                n_fail++; $display("FAIL b2b_data%0d: got none expected %h", k, want);
            end else if (obs_roll_q[base_q + k] !== want) begin
                n_fail++; $display("FAIL b2b_data%0d: got %h expected %h", k, obs_roll_q[base_q + k], want);
            end
        end
        n_tests++; if (obs_busy_rise - base_rise !== 3) begin n_fail++; $display("FAIL b2b_busy_low_between: got %0d busy rises expected 3", obs_busy_rise - base_rise); end
    endtask

    task automatic test_random();
        logic [31:0] vec;
        logic [7:0]  c;
        int          n;
        for (int it = 0; it < 40; it++) begin
            half = int'($urandom_range(3, 6));
            if ($urandom_range(0, 9) < 7) begin
                n = 16;
                c = ($urandom_range(0, 1) == 1) ? CMD_ROLL : 8'($urandom);
                vec = {16'h0, c, 8'($urandom)};
            end else begin
                n = int'($urandom_range(1, 20));
                vec = $urandom;
            end
            send_frame(vec, n, int'($urandom_range(5, 10)));
            n_tests++; if (obs_roll !== exp_roll) begin n_fail++; $display("FAIL rand%0d_roll_count: got %0d expected %0d", it, obs_roll, exp_roll); end
            n_tests++; if (obs_unk !== exp_unk) begin n_fail++; $display("FAIL rand%0d_unk_count: got %0d expected %0d", it, obs_unk, exp_unk); end
            n_tests++; if (obs_err !== exp_err) begin n_fail++; $display("FAIL rand%0d_err_count: got %0d expected %0d", it, obs_err, exp_err); end
            n_tests++; if (roll_data !== exp_roll_data) begin n_fail++; $display("FAIL rand%0d_roll_data: got %h expected %h", it, roll_data, exp_roll_data); end
            n_tests++; if (cmd_code !== exp_cmd) begin n_fail++; $display("FAIL rand%0d_cmd_code: got %h expected %h", it, cmd_code, exp_cmd); end
        end
    endtask

    task automatic test_exclusive();
        n_tests++; if (obs_multi !== 0) begin n_fail++; $display("FAIL strobe_exclusive: got %0d overlapping cycles expected 0", obs_multi); end
    endtask

    initial begin
        test_reset();
        test_roll();
        test_unknown();
        test_bad_length();
        test_timeout();
        test_reset_midframe();
        test_back_to_back();
        test_random();
        test_exclusive();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
